// File: rtl/add_sub_accumulator_if.sv
// ---------------------------------------------------------------------------
// add_sub_accumulator_if
// Bundles the operand-stream and result handshakes of the add/sub accumulator.
//   master : producer/consumer side (drives start, init_value, in_valid,
//            operand, mode, out_ready; observes the result and status)
//   slave  : accumulator side (the add_sub_accumulator block)
// Signals:
//   start/init_value        batch launch and accumulator seed
//   in_valid/in_ready       operand handshake, operand + mode (0 add, 1 sub)
//   out_valid/out_ready     result handshake
//   acc_out/cout_last/ovf_sticky/busy  result and status
// ---------------------------------------------------------------------------
interface add_sub_accumulator_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] init_value;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc_out;
  logic             cout_last;
  logic             ovf_sticky;
  logic             busy;

  modport master (
    output start, init_value, in_valid, operand, mode, out_ready,
    input  in_ready, out_valid, acc_out, cout_last, ovf_sticky, busy
  );

  modport slave (
    input  start, init_value, in_valid, operand, mode, out_ready,
    output in_ready, out_valid, acc_out, cout_last, ovf_sticky, busy
  );
endinterface

// File: rtl/add_sub_accumulator.sv
// ---------------------------------------------------------------------------
// add_sub_accumulator
// Multi-operand batch engine around a WIDTH-bit two's-complement add/sub.
// A batch is seeded on start, folds OP_COUNT operands (each add or subtract)
// into the accumulator, then holds the result on an output handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (discards any batch in progress)
//   bus  add_sub_accumulator_if.slave (see interface header)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module add_sub_accumulator #(
  parameter int WIDTH    = 4,
  parameter int OP_COUNT = 4
) (
  input logic                  clk,
  input logic                  rst,
  add_sub_accumulator_if.slave bus
);

  localparam int CNT_W = (OP_COUNT > 1) ? $clog2(OP_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             xfer_s;
  logic [WIDTH-1:0] op_eff_s;
  logic [WIDTH:0]   sum_s;
  logic             ovf_s;
  logic             last_s;

  // Add/sub datapath: subtract is acc + ~operand + 1, so the carry-in is mode.
  always_comb begin
    xfer_s   = in_ready_q && bus.in_valid;
    op_eff_s = bus.mode ? ~bus.operand : bus.operand;
    sum_s    = {1'b0, acc_q} + {1'b0, op_eff_s} + {{WIDTH{1'b0}}, bus.mode};
    // Overflow on the effective addend: same input signs, differing result sign.
    ovf_s    = (acc_q[WIDTH-1] == op_eff_s[WIDTH-1]) &&
               (sum_s[WIDTH-1] != acc_q[WIDTH-1]);
    last_s   = (cnt_q == LAST_CNT);
  end

  // Next-state and next-output logic for the IDLE/ACCUM/DONE controller.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.init_value;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (xfer_s) begin
          acc_d  = sum_s[WIDTH-1:0];
          cout_d = sum_s[WIDTH];
          ovf_d  = ovf_q | ovf_s;
          if (last_s) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake/status flags are registered copies decoded from the next state.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.acc_out    = acc_q;
  assign bus.cout_last  = cout_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: doc/add_sub_accumulator.md
# add_sub_accumulator

Sequential accumulator stage that sits directly downstream of the 4-bit universal adder/subtractor datapath. It accepts a stream of operands with per-operand add/subtract mode over a valid/ready handshake and folds each one into a running accumulator. It tracks the last carry-out and a sticky signed-overflow flag, then presents the final result on an output handshake after a fixed number of operations. It turns the combinational add/sub into a multi-operand batch engine for the lab datapath.

## Interface
- `WIDTH`, 4, operand/accumulator width in bits (two's complement).
- `OP_COUNT`, 4, operands accepted per batch (≥1).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin batch; sampled only in IDLE.
- `init_value` input WIDTH: accumulator seed, loaded on accepted `start`.
- `in_valid` input 1: operand/mode valid.
- `in_ready` output 1: block accepts operand this cycle.
- `operand` input WIDTH: B operand.
- `mode` input 1: 0 = add (acc + operand), 1 = subtract (acc − operand).
- `out_valid` output 1: batch result available.
- `out_ready` input 1: consumer accepts result.
- `acc_out` output WIDTH: accumulator value.
- `cout_last` output 1: carry-out of most recent operation (subtract: 1 = no borrow).
- `ovf_sticky` output 1: OR of signed overflow over all operations in batch.
- `busy` output 1: high in ACCUM or DONE.

## Operation
- States: IDLE, ACCUM, DONE. Reset → IDLE.
- Reset values: `acc_out`=0, `cout_last`=0, `ovf_sticky`=0, `in_ready`=0, `out_valid`=0, `busy`=0, internal op counter=0.
- IDLE: `start`=1 → acc←`init_value`, `cout_last`←0, `ovf_sticky`←0, counter←0, go ACCUM. `acc_out` otherwise holds last batch result.
- ACCUM: `in_ready`=1. Transfer when `in_valid`&&`in_ready`:
  - add: {c,s} = acc + operand.
  - sub: {c,s} = acc + ~operand + 1.
  - acc←s (modulo 2^WIDTH wrap), `cout_last`←c.
  - overflow: add when acc[MSB]==operand[MSB] && s[MSB]!=acc[MSB]; sub when acc[MSB]!=operand[MSB] && s[MSB]!=acc[MSB]. `ovf_sticky`←`ovf_sticky`|overflow.
  - counter++; on transfer with counter==OP_COUNT−1 → DONE.
- DONE: `in_ready`=0, `out_valid`=1; `acc_out`, `cout_last`, `ovf_sticky` stable. `out_valid`&&`out_ready` → IDLE.
- `start` ignored in ACCUM and DONE. `in_valid` ignored outside ACCUM. `mode`/`operand` are don't-care when no transfer.
- `rst` overrides all, in any state, including mid-batch; partial results discarded.

## Timing
- `start` sampled at edge k → ACCUM; `in_ready`=1 from cycle after k.
- One operand per cycle max; result of a transfer at edge j visible on `acc_out` after edge j.
- Minimum batch: start edge + OP_COUNT transfer edges; `out_valid` rises the cycle after the final transfer edge.
- `in_valid` gaps stall ACCUM with no state change.
- `out_ready` low holds DONE indefinitely; `out_valid` drops the cycle after the handshake edge.
- New `start` accepted no earlier than the first cycle in IDLE (one dead cycle after output handshake).
- `rst` high at edge → reset values visible the following cycle.

## Test plan
- Basic add: init 0, ops +1,+2,+3,+1, `out_ready`=1 → `out_valid` after 4th transfer, `acc_out`=7, `cout_last`=0, `ovf_sticky`=0.
- Overflow + sticky: init 5, ops +3 (acc 8, ovf), −3 (acc 5, c=1, ovf), +0, −0 → `acc_out`=5, `cout_last`=1, `ovf_sticky`=1.
- Borrow/wrap: init 4, ops −6 (acc 14, c=0, no ovf), +7 (acc 5, c=1), +7 (acc 12, ovf), −0 (c=1) → `acc_out`=12, `cout_last`=1, `ovf_sticky`=1.
- Backpressure: `in_valid` toggled with 2-cycle gaps, `start` pulsed during ACCUM and DONE, `out_ready` low 3 cycles in DONE → no extra transfers, `start` ignored, outputs stable, result matches ungapped run.
- Reset mid-batch: `rst` after 2 transfers → next cycle all outputs 0, state IDLE. A fresh `start` with init 3 and ops +1×4 → `acc_out`=7.
- Back-to-back batches: output handshake, then `start` on first IDLE cycle with init 15, ops −1×4 → `acc_out`=11, `cout_last`=1, `ovf_sticky`=0.
